// File: rtl/sd_dat_block_rx_pkg.sv
// sd_dat_block_rx_pkg: shared states, register map and CRC16 step for the SD 4-bit data block receiver.
package sd_dat_block_rx_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_CRC  = 3'd3;
   localparam logic [2:0] ST_END  = 3'd4;
   typedef enum logic [1:0] {REG_CTRL, REG_DATA, REG_CLKDIV, REG_LEVEL} reg_addr_e;
   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_IRQ_EN = 2;
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      return {crc[14:0], 1'b0} ^ ({16{crc[15] ^ din}} & CRC16_POLY);
   endfunction
endpackage

// File: rtl/sd_dat_block_rx_if.sv
// sd_dat_block_rx_if: Avalon-MM slave bus carrying CPU register accesses.
interface sd_dat_block_rx_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, read, write, writedata, input readdata);
   modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/sd_dat_block_rx_crc.sv
// sd_crc16_serial: bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT line.
module sd_crc16_serial
   import sd_dat_block_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);
   logic [15:0] crc_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) crc_q <= '0;
      else if (clear_i) crc_q <= '0;
      else if (en_i) crc_q <= crc16_step(crc_q, din_i);
   assign crc_o = crc_q;
endmodule

// File: rtl/sd_dat_block_rx.sv
// sd_dat_block_rx: receives one 4-bit SD data block, checks per-line CRC16 and end bit, buffers words for the CPU.
module sd_dat_block_rx
   import sd_dat_block_rx_pkg::*;
#(
   parameter int CLK_DIV       = 2,
   parameter int BLOCK_BYTES   = 512,
   parameter int TIMEOUT_EDGES = 65535,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                clk,
   input  logic                reset,
   sd_dat_block_rx_if.slave    bus,
   output logic                sd_clk_o,
   input  logic [3:0]          sd_dat_i,
   output logic                irq
);
   localparam int NW = $clog2(2 * BLOCK_BYTES);
   localparam int TW = $clog2(TIMEOUT_EDGES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [2:0]      state_q, state_d;
   logic [15:0]     div_q, hcnt_q;
   logic            sclk_q;
   logic [TW-1:0]   tcnt_q;
   logic [NW-1:0]   ncnt_q;
   logic [3:0]      ccnt_q, hi_q, crc_bits;
   logic [23:0]     word_q;
   logic            done_q, crc_err_q, timeout_q, irq_en_q;
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     cnt_q;
   logic [31:0]     mem_q [FIFO_DEPTH];
   logic [15:0]     crc_w [4];

   logic rd, ctrl_wr, abort, start, busy, empty, full, pop, push, run, half, sd_edge;
   logic dat_edge, tlast;

   assign rd       = bus.chipselect & bus.read;
   assign ctrl_wr  = bus.chipselect & bus.write & (bus.address == REG_CTRL);
   assign abort    = ctrl_wr & bus.writedata[CTRL_ABORT];
   assign busy     = state_q != ST_IDLE;
   assign start    = ctrl_wr & bus.writedata[CTRL_START] & ~abort & ~busy;
   assign empty    = cnt_q == '0;
   assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign pop      = rd & (bus.address == REG_DATA) & ~empty;
   // A full FIFO stalls the card clock only while payload is still arriving.
   assign run      = busy & ~abort & ~(state_q == ST_DATA & full & ~pop);
   assign half     = run & (hcnt_q >= div_q - 16'd1);
   assign sd_edge  = half & ~sclk_q;
   assign dat_edge = sd_edge & (state_q == ST_DATA);
   assign push     = dat_edge & (ncnt_q[2:0] == 3'b111);
   assign tlast    = tcnt_q == TW'(TIMEOUT_EDGES - 1);
   assign sd_clk_o = sclk_q;
   assign irq      = irq_en_q & (done_q | crc_err_q | timeout_q);

   for (genvar g = 0; g < 4; g++) begin : g_crc
      sd_crc16_serial u_crc (
         .clk     (clk),
         .rst     (reset),
         .clear_i (start),
         .en_i    (dat_edge),
         .din_i   (sd_dat_i[g]),
         .crc_o   (crc_w[g])
      );
      assign crc_bits[g] = crc_w[g][~ccnt_q];
   end

   always_comb begin
      state_d = state_q;
      if (sd_edge)
         case (state_q)
            ST_WAIT: state_d = (sd_dat_i == 4'h0) ? ST_DATA : tlast ? ST_IDLE : ST_WAIT;
            ST_DATA: state_d = (ncnt_q == NW'(2 * BLOCK_BYTES - 1)) ? ST_CRC : ST_DATA;
            ST_CRC:  state_d = (ccnt_q == 4'd15) ? ST_END : ST_CRC;
            ST_END:  state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
      if (start) state_d = ST_WAIT;
      if (abort) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= ST_IDLE;
         div_q     <= 16'(CLK_DIV);
         hcnt_q    <= '0;
         sclk_q    <= 1'b0;
         tcnt_q    <= '0;
         ncnt_q    <= '0;
         ccnt_q    <= '0;
         hi_q      <= '0;
         word_q    <= '0;
         done_q    <= 1'b0;
         crc_err_q <= 1'b0;
         timeout_q <= 1'b0;
         irq_en_q  <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         bus.readdata <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= (~busy | half) ? '0 : hcnt_q + {15'b0, run};
         sclk_q  <= (abort | ~busy) ? 1'b0 : sclk_q ^ half;
         tcnt_q  <= start ? '0 : tcnt_q + TW'(sd_edge & (state_q == ST_WAIT));
         ncnt_q  <= start ? '0 : ncnt_q + NW'(dat_edge);
         ccnt_q  <= start ? '0 : ccnt_q + 4'(sd_edge & (state_q == ST_CRC));
         if (dat_edge & ~ncnt_q[0]) hi_q <= sd_dat_i;
         for (int b = 0; b < 3; b++)
            if (dat_edge & ncnt_q[0] & (ncnt_q[2:1] == 2'(b))) word_q[8*b +: 8] <= {hi_q, sd_dat_i};
         if (start) begin
            done_q    <= 1'b0;
            crc_err_q <= 1'b0;
            timeout_q <= 1'b0;
         end else if (sd_edge) begin
            if (state_q == ST_WAIT && sd_dat_i != 4'h0 && tlast) timeout_q <= 1'b1;
            if (state_q == ST_CRC && crc_bits != sd_dat_i) crc_err_q <= 1'b1;
            if (state_q == ST_END) begin
               done_q <= 1'b1;
               if (sd_dat_i != 4'hF) crc_err_q <= 1'b1;
            end
         end
         if (ctrl_wr) irq_en_q <= bus.writedata[CTRL_IRQ_EN];
         if (bus.chipselect & bus.write & (bus.address == REG_CLKDIV))
            div_q <= (bus.writedata[15:0] == 16'd0) ? 16'd1 : bus.writedata[15:0];
         wptr_q <= (start | abort) ? '0 : wptr_q + AW'(push);
         rptr_q <= (start | abort) ? '0 : rptr_q + AW'(pop);
         cnt_q  <= (start | abort) ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
         if (rd)
            bus.readdata <= (bus.address == REG_CTRL)   ? {27'b0, irq_en_q, timeout_q, crc_err_q, done_q, busy} :
                            (bus.address == REG_DATA)   ? (empty ? 32'd0 : mem_q[rptr_q]) :
                            (bus.address == REG_CLKDIV) ? {16'b0, div_q} :
                                                          {{(31-AW){1'b0}}, cnt_q};
      end

   always_ff @(posedge clk)
      if (push) mem_q[wptr_q] <= {hi_q, sd_dat_i, word_q};
endmodule

// File: tb/tb_sd_dat_block_rx.sv
// tb_sd_dat_block_rx: register vectors plus a card model streaming full blocks through the receiver.
module tb_sd_dat_block_rx;
   import sd_dat_block_rx_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] dat;
   logic       sd_clk_o, irq;
   logic       card_go = 1'b0;

   sd_dat_block_rx_if bus();

   sd_dat_block_rx #(.CLK_DIV(2), .BLOCK_BYTES(512), .TIMEOUT_EDGES(16), .FIFO_DEPTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .sd_clk_o (sd_clk_o),
      .sd_dat_i (dat),
      .irq      (irq)
   );

   initial forever #5 clk = ~clk;

   int n_pass = 0, n_total = 0;
   logic [3:0] stream [0:1199];
   int slen = 0, sp = 0, got, bad;

   // Card: presents stream[sp], advancing after every sd_clk rising edge.
   initial begin
      dat = 4'hF;
      forever begin
         @(posedge sd_clk_o or posedge card_go);
         if (card_go) sp = 0;
         else sp = sp + 1;
         dat = (sp < slen) ? stream[sp] : 4'hF;
      end
   end

   typedef struct {
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] e;
      string       name;
   } vec_t;
   vec_t vt [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.read = 1'b0;
      d = bus.readdata;
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return fb ? ((c << 1) ^ 16'h1021) : (c << 1);
   endfunction

   function automatic logic [31:0] exp_word(input int n);
      logic [31:0] w;
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((4 * n + j) % 256);
      return w;
   endfunction

   task automatic build(input bit flip);
      logic [15:0] crc [4];
      logic [7:0]  b;
      logic [3:0]  n;
      for (int i = 0; i < 4; i++) crc[i] = '0;
      for (int i = 0; i < 3; i++) stream[i] = 4'hF;
      stream[3] = 4'h0;
      slen = 4;
      for (int k = 0; k < 512; k++) begin
         b = 8'(k % 256);
         for (int h = 0; h < 2; h++) begin
            n = (h == 0) ? b[7:4] : b[3:0];
            stream[slen] = n;
            slen++;
            for (int i = 0; i < 4; i++) crc[i] = crc_upd(crc[i], n[i]);
         end
      end
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 4; i++) n[i] = crc[i][15-j];
         if (flip && j == 0) n[2] = ~n[2];
         stream[slen] = n;
         slen++;
      end
      stream[slen] = 4'hF;
      slen++;
   endtask

   task automatic kick();
      @(negedge clk);
      card_go = 1'b1;
      #1 card_go = 1'b0;
      bus_wr(REG_CTRL, 32'h5);
   endtask

   task automatic drain(input string tag);
      logic [31:0] lv, w;
      int g = 0;
      while (got < 128 && g < 12000) begin
         bus_rd(REG_LEVEL, lv);
         if (lv != 0) begin
            bus_rd(REG_DATA, w);
            if (w !== exp_word(got)) bad++;
            got++;
         end
         g++;
      end
      chk({tag, "_words"}, got, 128);
      chk({tag, "_data"}, bad, 0);
   endtask

   task automatic wait_idle(input string tag, output logic [31:0] st);
      int g = 0;
      do begin
         bus_rd(REG_CTRL, st);
         g++;
      end while (st[0] && g < 3000);
      chk({tag, "_busy"}, {31'b0, st[0]}, 0);
   endtask

   task automatic run_block(input bit flip, input logic [31:0] exp_st, input string tag);
      logic [31:0] st;
      build(flip);
      kick();
      got = 0; bad = 0;
      drain(tag);
      wait_idle(tag, st);
      chk({tag, "_status"}, st, exp_st);
      chk({tag, "_irq"}, {31'b0, irq}, 1);
   endtask

   initial begin
      logic [31:0] r, lv0, lv1, st;
      int g, s0, s1, n;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = '0; bus.writedata = '0;
      vt[0]  = '{1'b0, REG_CTRL,   32'h0,       32'h0,  "rst_ctrl"};
      vt[1]  = '{1'b0, REG_CLKDIV, 32'h0,       32'h2,  "rst_clkdiv"};
      vt[2]  = '{1'b0, REG_LEVEL,  32'h0,       32'h0,  "rst_level"};
      vt[3]  = '{1'b0, REG_DATA,   32'h0,       32'h0,  "empty_data"};
      vt[4]  = '{1'b1, REG_CLKDIV, 32'h5,       32'h0,  ""};
      vt[5]  = '{1'b0, REG_CLKDIV, 32'h0,       32'h5,  "clkdiv_5"};
      vt[6]  = '{1'b1, REG_CLKDIV, 32'h0,       32'h0,  ""};
      vt[7]  = '{1'b0, REG_CLKDIV, 32'h0,       32'h1,  "clkdiv_0_as_1"};
      vt[8]  = '{1'b1, REG_CLKDIV, 32'h10003,   32'h0,  ""};
      vt[9]  = '{1'b0, REG_CLKDIV, 32'h0,       32'h3,  "clkdiv_low16"};
      vt[10] = '{1'b1, REG_CTRL,   32'h4,       32'h0,  ""};
      vt[11] = '{1'b0, REG_CTRL,   32'h0,       32'h10, "irq_en_set"};
      vt[12] = '{1'b0, REG_DATA,   32'h0,       32'h0,  "empty_data_after_ctrl"};
      vt[13] = '{1'b1, REG_CTRL,   32'h0,       32'h0,  ""};
      vt[14] = '{1'b0, REG_CTRL,   32'h0,       32'h0,  "irq_en_clr"};
      vt[15] = '{1'b1, REG_CLKDIV, 32'h2,       32'h0,  ""};
      vt[16] = '{1'b0, REG_CLKDIV, 32'h0,       32'h2,  "clkdiv_2"};

      repeat (3) @(negedge clk);
      chk("rst_readdata", bus.readdata, 0);
      chk("rst_sd_clk", {31'b0, sd_clk_o}, 0);
      chk("rst_irq", {31'b0, irq}, 0);
      reset = 1'b0;

      for (int i = 0; i < 17; i++)
         if (vt[i].w) bus_wr(vt[i].a, vt[i].d);
         else begin
            bus_rd(vt[i].a, r);
            chk(vt[i].name, r, vt[i].e);
         end

      // Good block, then one with a corrupted line-2 CRC bit.
      run_block(1'b0, 32'h12, "blk_ok");
      run_block(1'b1, 32'h16, "blk_crc_err");

      // Card never sends a start bit.
      slen = 0;
      kick();
      wait_idle("timeout", st);
      chk("timeout_edges", sp, 16);
      chk("timeout_status", st, 32'h18);
      bus_rd(REG_LEVEL, r);
      chk("timeout_level", r, 0);
      chk("timeout_irq", {31'b0, irq}, 1);
      chk("timeout_sd_clk", {31'b0, sd_clk_o}, 0);

      // Flow control: leave the FIFO full, then release one word.
      build(1'b0);
      kick();
      g = 0;
      do begin
         bus_rd(REG_LEVEL, r);
         g++;
      end while (r != 8 && g < 500);
      chk("full_level", r, 8);
      s0 = sp;
      repeat (40) @(negedge clk);
      chk("full_clock_stopped", sp, s0);
      bus_rd(REG_LEVEL, r);
      chk("full_level_held", r, 8);
      bus_rd(REG_DATA, r);
      chk("full_word0", r, 32'h03020100);
      g = 0;
      while (sp == s0 && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk("full_resumed", {31'b0, sp != s0}, 1);
      got = 1; bad = 0;
      drain("full");
      wait_idle("full", st);
      chk("full_status", st, 32'h12);

      // Abort around payload nibble 300, then a clean block.
      build(1'b0);
      kick();
      got = 0; bad = 0; g = 0;
      while (sp < 304 && g < 5000) begin
         bus_rd(REG_LEVEL, r);
         if (r != 0) begin
            bus_rd(REG_DATA, r);
            if (r !== exp_word(got)) bad++;
            got++;
         end
         g++;
      end
      chk("abort_reached_300", {31'b0, sp >= 304}, 1);
      chk("abort_prefix_data", bad, 0);
      bus_wr(REG_CTRL, 32'h6);
      chk("abort_sd_clk", {31'b0, sd_clk_o}, 0);
      bus_rd(REG_CTRL, r);
      chk("abort_status", r, 32'h10);
      bus_rd(REG_LEVEL, r);
      chk("abort_level", r, 0);
      chk("abort_irq", {31'b0, irq}, 0);
      run_block(1'b0, 32'h12, "after_abort");

      // START while busy must not restart or flush.
      build(1'b0);
      kick();
      g = 0;
      do begin
         bus_rd(REG_LEVEL, lv0);
         g++;
      end while (lv0 < 2 && g < 500);
      bus_wr(REG_CTRL, 32'h5);
      bus_rd(REG_LEVEL, lv1);
      chk("start_busy_no_flush", {31'b0, (lv1 >= lv0) && (lv1 != 0)}, 1);
      bus_rd(REG_CTRL, r);
      chk("start_busy_still_busy", {31'b0, r[0]}, 1);
      bus_wr(REG_CTRL, 32'h6);

      // CLKDIV=0 runs sd_clk at one clk per half-period.
      bus_wr(REG_CLKDIV, 32'h0);
      build(1'b0);
      kick();
      s0 = sp; g = 0;
      while (sp == s0 && g < 50) begin
         @(negedge clk);
         g++;
      end
      s1 = sp; n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sp == s1 && n < 50);
      chk("div1_period", n, 2);
      bus_wr(REG_CTRL, 32'h6);
      bus_wr(REG_CLKDIV, 32'h2);

      // Reset in the middle of the payload.
      build(1'b0);
      kick();
      g = 0;
      while (sp < 50 && g < 500) begin
         @(negedge clk);
         g++;
      end
      bus_rd(REG_LEVEL, r);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_sd_clk", {31'b0, sd_clk_o}, 0);
      chk("midrst_irq", {31'b0, irq}, 0);
      chk("midrst_readdata", bus.readdata, 0);
      reset = 1'b0;
      bus_rd(REG_CTRL, r);
      chk("midrst_ctrl", r, 0);
      bus_rd(REG_LEVEL, r);
      chk("midrst_level", r, 0);
      bus_rd(REG_CLKDIV, r);
      chk("midrst_clkdiv", r, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
